// File: rtl/lane_pkg.sv
// Shared definitions for the lane mux front end.
// Holds the symbol width, the number of mux lanes, the default FIFO
// geometry and thresholds, and a ceil-log2 helper that derives address
// widths from entry counts.
package lane_pkg;

  localparam int SYMBOL_W     = 8;
  localparam int NUM_LANES    = 2;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_AF_LEVEL = 6;
  localparam int DEF_AE_LEVEL = 2;

  // Ceiling log2. The result for 8 is 3. The result for 1 is 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for lane_fifo_8bit. It holds DEPTH words of DATA_W bits.
// Ports:
//   clk   - rising-edge clock for the write port
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data at raddr
// The contents are deliberately not reset. The FIFO pointers decide which
// words are valid.
module fifo_mem
  import lane_pkg::*;
#(
  parameter int DATA_W = SYMBOL_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port: one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // A read and a write to the same address return the old word.
  // The FIFO relies on this when it is full and pushes and pops together.
  assign rdata = mem_r[raddr];

endmodule

// File: rtl/lane_fifo_8bit.sv
// Per-lane synchronous FIFO in front of the 2:1 8-bit lane mux.
// Ports:
//   clk, reset_L   - rising-edge clock, asynchronous active-low reset
//   push, data_in  - write request and symbol
//   pop            - read request from the downstream arbiter
//   data_out       - registered symbol popped on the last edge
//   valid_out      - data_out was loaded by a pop on the last edge
//   full, empty, almost_full, almost_empty - combinational decode of count
//   count          - occupancy, 0..DEPTH
//   overflow_err   - sticky; set when a push is dropped
//   underflow_err  - sticky; set when a pop arrives while empty
module lane_fifo_8bit
  import lane_pkg::*;
#(
  parameter int DATA_W   = SYMBOL_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = clog2(DEPTH),
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow_err,
  output logic              underflow_err
);

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_nxt_s;
  logic [DATA_W-1:0] data_out_r;
  logic              valid_out_r;
  logic              overflow_r;
  logic              underflow_r;
  logic [DATA_W-1:0] rd_data_s;
  logic              push_ok_s;
  logic              pop_ok_s;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok_s),
    .waddr (wr_ptr_r),
    .wdata (data_in),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  assign empty        = (count_r == {(ADDR_W+1){1'b0}});
  assign full         = (count_r == (ADDR_W+1)'(DEPTH));
  assign almost_full  = (count_r >= (ADDR_W+1)'(AF_LEVEL));
  assign almost_empty = (count_r <= (ADDR_W+1)'(AE_LEVEL));

  // A pop is taken only when there is data. There is no bypass from
  // data_in. A push is taken when the FIFO is not full. It is also taken
  // when the FIFO is full and a pop frees the slot in the same cycle.
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);

  // Next occupancy from the accepted push and pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + (ADDR_W+1)'(1);
      2'b01:   count_nxt_s = count_r - (ADDR_W+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, output register and sticky error flags.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      count_r     <= {(ADDR_W+1){1'b0}};
      data_out_r  <= {DATA_W{1'b0}};
      valid_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r    <= rd_ptr_r + ADDR_W'(1);
        data_out_r  <= rd_data_s;
        valid_out_r <= 1'b1;
      end else begin
        valid_out_r <= 1'b0;
      end
      if (push & ~push_ok_s) begin
        overflow_r <= 1'b1;
      end
      if (pop & empty) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign count         = count_r;
  assign data_out      = data_out_r;
  assign valid_out     = valid_out_r;
  assign overflow_err  = overflow_r;
  assign underflow_err = underflow_r;

endmodule

// File: doc/lane_fifo_8bit.md
Name: lane_fifo_8bit

Overview:
- Per-lane synchronous FIFO that buffers 8-bit symbols in front of the 2:1 8-bit lane mux.
- Two instances are used, one per mux input; each one drives one data/valid input pair.
- The downstream arbiter pops each FIFO on its turn.
- Provides registered data_out with valid_out, status flags for upstream flow control, and sticky error flags.

Parameters:
- DATA_W, 8, symbol width in bits.
- DEPTH, 8, number of entries; must be a power of 2 and at least 4.
- ADDR_W, 3, log2(DEPTH).
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  asynchronous, active-low reset.
- push  input  1  write request; accepted when not full, or when full with an accepted pop in the same cycle.
- data_in  input  DATA_W  write data, sampled with push.
- pop  input  1  read request from the downstream mux/arbiter.
- data_out  output  DATA_W  registered read data.
- valid_out  output  1  data_out holds a symbol popped on the previous edge.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow_err  output  1  sticky; set by a dropped push.
- underflow_err  output  1  sticky; set by a pop on empty.

Behaviour:
- Reset (reset_L=0, asynchronous, takes effect immediately):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, overflow_err=0, underflow_err=0.
  - Therefore empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all stored entries. The first accepted push after reset_L rises writes to address 0.
- Write: push accepted -> mem[wr_ptr]<=data_in; wr_ptr increments modulo DEPTH (natural wrap of the ADDR_W counter).
- Read: pop with count>0 -> data_out<=mem[rd_ptr], valid_out<=1, rd_ptr increments modulo DEPTH.
  - Latency is 1 clock: the symbol appears on the edge that accepts the pop.
- Pop not accepted (pop=0, or pop on empty) -> valid_out<=0 and data_out holds its last value.
- Occupancy: count += accepted push - accepted pop. Every flag is a combinational decode of count.
- Push and pop in the same cycle:
  - 0<count<DEPTH: both accepted; count unchanged.
  - count==DEPTH: pop accepted, so push is also accepted. The write goes to the slot just freed (wr_ptr==rd_ptr); the read returns the old entry. count stays DEPTH; no overflow.
  - count==0: no bypass. Pop is rejected (underflow_err<=1, valid_out<=0); push is accepted; count becomes 1.
- Push with count==DEPTH and no pop: data dropped, pointers and count unchanged, overflow_err<=1.
- Error flags stay set until reset.
- No output is X after reset. data_in is ignored whenever push=0.

Decomposition:
- Shared package lane_pkg holds:
  - SYMBOL_W=8 and the lane count (2);
  - default DEPTH and AF/AE levels;
  - a function clog2 used to derive ADDR_W.
- One sub-module, fifo_mem: a DEPTH x DATA_W register array.
  - Write port: we, waddr, wdata.
  - Read port: combinational read at raddr.
  - No reset.
- Pointers, count, flags and the output register stay in lane_fifo_8bit.

Test Plan:
- Reset then idle: hold reset_L=0 for 2 cycles, release, idle 3 cycles -> empty=1, almost_empty=1, count=0, valid_out=0, data_out=0x00, both error flags 0.
- Fill and drain order: push 0x11..0x18 on 8 consecutive cycles -> full=1, almost_full=1 from count=6, count=8. Then pop 8 cycles -> data_out 0x11..0x18 in order, each on the pop edge, with valid_out=1. After that, empty=1 and valid_out=0 on the next idle cycle.
- Overflow: with the FIFO full, push 0xAA without pop -> count stays 8, overflow_err=1 (sticky), 0xAA never appears on data_out. Simultaneous push 0xBB + pop -> 0x11 out, count=8, 0xBB is read last.
- Underflow: on empty, pop=1 alone -> underflow_err=1, valid_out=0. Push 0x5C + pop in the same cycle on empty -> count=1, valid_out=0; the next pop returns 0x5C.
- Wrap-around: interleave push/pop for 20 cycles with values 0x00..0x13 at occupancy 3 -> output sequence matches input order across pointer wrap, count stays 3, almost_empty=0, almost_full=0.
- Async reset mid-stream: assert reset_L=0 between clock edges with count=5 -> flags, count and valid_out change immediately without a clock edge. After release, push 0x77 then pop -> data_out=0x77.
